// File: rtl/tt_ctrl_pkg.sv
// Shared encodings for the Tiny Tapeout project sequencer: command opcodes and FSM states.
package tt_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_STOP  = 2'd0,
    OP_RESET = 2'd1,
    OP_RUN   = 2'd2,
    OP_STEP  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_e;

endpackage

// File: rtl/tt_project_ctrl.sv
// Sequencer generating the Tiny Tapeout project clock, reset and enable from UserCLK,
// driven by a valid/ready command port (timed reset, free run, exact N-period stepping).
module tt_project_ctrl
  import tt_ctrl_pkg::*;
#(
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              UserCLK,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              CLK_TT_PROJECT,
  output logic              RST_N_TT_PROJECT,
  output logic              ENA_TT_PROJECT
);

  // Handshake: a command (cmd_op, cmd_arg) transfers on a rising UserCLK edge where
  // cmd_valid && cmd_ready; cmd_ready is high only in IDLE and RUN, and the argument
  // is captured at that edge so later changes of cmd_arg are ignored.
  state_e             state_q;
  logic               clk_q;
  logic               rst_n_q;
  logic               ena_q;
  logic               done_q;
  logic [STEP_W-1:0]  per_q;
  logic [CNT_W-1:0]   cyc_q;

  cmd_op_e            op;
  logic               accept;
  state_e             start_state;
  logic               start_done;
  logic [STEP_W-1:0]  start_per;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Where an accepted command leads, shared by IDLE and by RUN once its period is closed.
  always_comb begin
    start_state = ST_IDLE;
    start_done  = 1'b0;
    start_per   = cmd_arg;
    case (op)
      OP_STOP:  start_done = 1'b1;
      OP_RESET: begin
        start_state = ST_RST;
        start_per   = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
      end
      OP_RUN:   start_state = ST_RUN;
      OP_STEP:  begin
        if (cmd_arg == '0) start_done  = 1'b1;
        else               start_state = ST_STEP;
      end
      default:  start_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      clk_q   <= 1'b0;
      rst_n_q <= 1'b0;
      ena_q   <= 1'b0;
      done_q  <= 1'b0;
      per_q   <= '0;
      cyc_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          clk_q <= 1'b0;
          if (accept) begin
            state_q <= start_state;
            per_q   <= start_per;
            done_q  <= start_done;
          end
        end
        ST_RUN: begin
          if (clk_q) cyc_q <= cyc_q + CNT_W'(1);
          // Any command other than RUN closes the current period (CLK ends low) before switching.
          if (accept && op != OP_RUN) begin
            clk_q   <= 1'b0;
            state_q <= start_state;
            per_q   <= start_per;
            done_q  <= start_done;
          end else begin
            clk_q <= ~clk_q;
          end
        end
        ST_RST, ST_STEP: begin
          if (!clk_q) begin
            clk_q <= 1'b1;
            if (state_q == ST_RST) begin
              rst_n_q <= 1'b0;
              ena_q   <= 1'b0;
            end
          end else begin
            clk_q <= 1'b0;
            if (per_q == STEP_W'(1)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
              if (state_q == ST_RST) begin
                cyc_q   <= '0;
                rst_n_q <= 1'b1;
                ena_q   <= 1'b1;
              end else begin
                cyc_q <= cyc_q + CNT_W'(1);
              end
            end else begin
              per_q <= per_q - STEP_W'(1);
              cyc_q <= cyc_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done             = done_q;
  assign cycle_cnt        = cyc_q;
  assign CLK_TT_PROJECT   = clk_q;
  assign RST_N_TT_PROJECT = rst_n_q;
  assign ENA_TT_PROJECT   = ena_q;

endmodule

// File: tb/tb_tt_project_ctrl.sv
// Directed bench for tt_project_ctrl: expected cycle_cnt values are queued per command
// and compared when done pulses; timing and pin levels are checked step by step.
module tb_tt_project_ctrl;
  import tt_ctrl_pkg::*;

  localparam int STEP_W = 16;
  localparam int CNT_W  = 32;

  logic              UserCLK = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic [STEP_W-1:0] cmd_arg = '0;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  cycle_cnt;
  logic              CLK_TT_PROJECT;
  logic              RST_N_TT_PROJECT;
  logic              ENA_TT_PROJECT;

  int               n_checks = 0;
  int               n_pass = 0;
  int               rises = 0;
  int               r0;
  int               w;
  logic             clk_prev = 1'b0;
  logic             changed;
  logic [CNT_W-1:0] exp_q[$];

  tt_project_ctrl #(.STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
    .UserCLK          (UserCLK),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_arg          (cmd_arg),
    .busy             (busy),
    .done             (done),
    .cycle_cnt        (cycle_cnt),
    .CLK_TT_PROJECT   (CLK_TT_PROJECT),
    .RST_N_TT_PROJECT (RST_N_TT_PROJECT),
    .ENA_TT_PROJECT   (ENA_TT_PROJECT)
  );

  // Clock / watchdog
  always #5 UserCLK = ~UserCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor samples 1ns after each edge; the main sequence samples at 2ns.
  always @(posedge UserCLK) begin
    #1;
    if (CLK_TT_PROJECT === 1'b1 && clk_prev === 1'b0) rises = rises + 1;
    clk_prev = CLK_TT_PROJECT;
    if (done === 1'b1) begin
      check("done_has_expectation", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check("done_cycle_cnt", cycle_cnt, exp_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge UserCLK);
    #2;
  endtask

  task automatic send(input logic [1:0] op, input logic [STEP_W-1:0] arg, output int waited);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    waited    = 0;
    while (!cmd_ready && waited < 50) begin
      cyc();
      waited++;
    end
    check("send_ready_within_budget", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    cmd_arg   = STEP_W'($urandom_range(0, 65535));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_clk"},   CLK_TT_PROJECT, 0);
    check({tag, "_rstn"},  RST_N_TT_PROJECT, 0);
    check({tag, "_ena"},   ENA_TT_PROJECT, 0);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_cnt"},   cycle_cnt, 0);
  endtask

  initial begin
    // Power-on
    rst_n = 1'b0;
    repeat (3) cyc();
    check_reset_values("in_reset");
    rst_n = 1'b1;
    cyc();
    check_reset_values("after_release");
    changed = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (CLK_TT_PROJECT !== 1'b0 || RST_N_TT_PROJECT !== 1'b0 || ENA_TT_PROJECT !== 1'b0 ||
          cmd_ready !== 1'b1 || busy !== 1'b0 || cycle_cnt !== '0) changed = 1'b1;
    end
    check("idle_100_stable", changed, 0);

    // RESET 3
    exp_q.push_back(0);
    send(OP_RESET, 3, w);
    check("rst3_k_clk", CLK_TT_PROJECT, 0);
    check("rst3_k_busy", busy, 1);
    check("rst3_k_ready", cmd_ready, 0);
    for (int j = 1; j <= 6; j++) begin
      cyc();
      check("rst3_clk", CLK_TT_PROJECT, 64'(j % 2));
      check("rst3_rstn", RST_N_TT_PROJECT, 64'(j == 6));
      check("rst3_ena", ENA_TT_PROJECT, 64'(j == 6));
      check("rst3_ready", cmd_ready, 64'(j == 6));
      check("rst3_done", done, 64'(j == 6));
    end
    cyc();
    check("rst3_done_one_cycle", done, 0);
    check("rst3_cnt", cycle_cnt, 0);

    // STEP 5, second STEP offered mid-way
    r0 = rises;
    exp_q.push_back(5);
    send(OP_STEP, 5, w);
    for (int j = 1; j <= 10; j++) begin
      cyc();
      check("step5_ready", cmd_ready, 64'(j == 10));
      check("step5_done", done, 64'(j == 10));
      if (j == 5) begin
        cmd_valid = 1'b1;
        cmd_op    = OP_STEP;
        cmd_arg   = 2;
        exp_q.push_back(7);
      end
    end
    check("step5_rises", rises - r0, 5);
    check("step5_cnt", cycle_cnt, 5);
    cyc();
    cmd_valid = 1'b0;
    cmd_arg   = STEP_W'($urandom_range(0, 65535));
    check("step2_accepted_busy", busy, 1);
    check("step2_accepted_ready", cmd_ready, 0);
    repeat (4) cyc();
    check("step2_done", done, 1);
    check("step2_cnt", cycle_cnt, 7);

    // RUN, STOP with CLK high
    send(OP_RUN, 0, w);
    check("run1_busy", busy, 1);
    check("run1_ready", cmd_ready, 1);
    repeat (7) cyc();
    check("run1_clk_high", CLK_TT_PROJECT, 1);
    exp_q.push_back(11);
    send(OP_STOP, 0, w);
    check("stop_hi_wait", w, 0);
    check("stop_hi_clk", CLK_TT_PROJECT, 0);
    check("stop_hi_busy", busy, 0);
    check("stop_hi_done", done, 1);
    cyc();
    check("stop_hi_clk_held", CLK_TT_PROJECT, 0);
    check("stop_hi_done_off", done, 0);

    // RUN, STOP with CLK low
    send(OP_RUN, 0, w);
    repeat (6) cyc();
    check("run2_clk_low", CLK_TT_PROJECT, 0);
    r0 = rises;
    exp_q.push_back(14);
    send(OP_STOP, 0, w);
    check("stop_lo_clk", CLK_TT_PROJECT, 0);
    check("stop_lo_busy", busy, 0);
    check("stop_lo_done", done, 1);
    check("stop_lo_no_rise", rises - r0, 0);

    // RUN then STEP 2 directly
    send(OP_RUN, 0, w);
    repeat (3) cyc();
    exp_q.push_back(18);
    send(OP_STEP, 2, w);
    check("run_step_clk", CLK_TT_PROJECT, 0);
    check("run_step_busy", busy, 1);
    check("run_step_ready", cmd_ready, 0);
    repeat (4) cyc();
    check("run_step_done", done, 1);
    check("run_step_cnt", cycle_cnt, 18);

    // STEP 0
    r0 = rises;
    exp_q.push_back(18);
    send(OP_STEP, 0, w);
    check("step0_done", done, 1);
    check("step0_busy", busy, 0);
    cyc();
    check("step0_clk", CLK_TT_PROJECT, 0);
    check("step0_no_rise", rises - r0, 0);
    check("step0_done_off", done, 0);

    // RESET 0 acts as one period
    exp_q.push_back(0);
    send(OP_RESET, 0, w);
    check("rst0_k_rstn", RST_N_TT_PROJECT, 1);
    check("rst0_k_busy", busy, 1);
    cyc();
    check("rst0_rise_clk", CLK_TT_PROJECT, 1);
    check("rst0_rise_rstn", RST_N_TT_PROJECT, 0);
    check("rst0_rise_ena", ENA_TT_PROJECT, 0);
    cyc();
    check("rst0_fall_clk", CLK_TT_PROJECT, 0);
    check("rst0_fall_rstn", RST_N_TT_PROJECT, 1);
    check("rst0_fall_ena", ENA_TT_PROJECT, 1);
    check("rst0_done", done, 1);
    check("rst0_cnt", cycle_cnt, 0);

    // Async reset mid-STEP 1000
    exp_q.push_back(1000);
    send(OP_STEP, 1000, w);
    repeat (37) cyc();
    check("step1000_running", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    check_reset_values("async_release");
    repeat (5) cyc();
    check("post_reset_idle", busy, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
